s_mem_rd_arbiter: RTL

//  Sequences and shares the single read port of the S coefficient memory between the EVP and EVB engines.

---
 rtl/s_mem_rd_arbiter_if.sv | 35 +++
 rtl/s_mem_rd_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/s_mem_rd_arbiter_if.sv
// s_mem_rd_arbiter_if: S memory read-port bundle shared by the EVP/EVB engines, the arbiter and the S memory.
// Defining S_ARB_PERF_EN adds the contention and forced-handover counter signals.
interface s_mem_rd_arbiter_if #(
  parameter int S_SIZE = 88,
  parameter int DATA_W = 16
);
  localparam int ADDR_W = (S_SIZE <= 1) ? 1 : $clog2(S_SIZE);
  logic [7:0]        instr;
  logic              req_evp, req_evb, gnt_evp, gnt_evb, rd_en_S, rvalid_evp, rvalid_evb, addr_err;
  logic [ADDR_W-1:0] addr_evp, addr_evb, rd_addr_S;
  logic [DATA_W-1:0] rd_data_S, rd_data;
`ifdef S_ARB_PERF_EN
  logic [15:0]       contend_cnt;
  logic [7:0]        handover_cnt;
  modport slave (
    input  instr, req_evp, addr_evp, req_evb, addr_evb, rd_data_S,
    output gnt_evp, gnt_evb, rd_en_S, rd_addr_S, rd_data, rvalid_evp, rvalid_evb, addr_err,
           contend_cnt, handover_cnt
  );
  modport master (
    output instr, req_evp, addr_evp, req_evb, addr_evb, rd_data_S,
    input  gnt_evp, gnt_evb, rd_en_S, rd_addr_S, rd_data, rvalid_evp, rvalid_evb, addr_err,
           contend_cnt, handover_cnt
  );
`else
  modport slave (
    input  instr, req_evp, addr_evp, req_evb, addr_evb, rd_data_S,
    output gnt_evp, gnt_evb, rd_en_S, rd_addr_S, rd_data, rvalid_evp, rvalid_evb, addr_err
  );
  modport master (
    output instr, req_evp, addr_evp, req_evb, addr_evb, rd_data_S,
    input  gnt_evp, gnt_evb, rd_en_S, rd_addr_S, rd_data, rvalid_evp, rvalid_evb, addr_err
  );
`endif
endinterface

// File: rtl/s_mem_rd_arbiter.sv
// s_mem_rd_arbiter: round-robin, burst-limited sharing of the S memory read port between EVP and EVB.
// Defining S_ARB_PERF_EN adds saturating contention (16b) and forced-handover (8b) counters.
module s_mem_rd_arbiter #(
  parameter int S_SIZE    = 88,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 16
) (
  input logic               clk,
  input logic               rst,
  s_mem_rd_arbiter_if.slave bus
);
  localparam int ADDR_W = (S_SIZE <= 1) ? 1 : $clog2(S_SIZE);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [7:0] I_EVP = 8'd1, I_EVB = 8'd2, I_RST = 8'd3;
  typedef enum logic [1:0] {IDLE, OWN_EVP, OWN_EVB} state_t;
  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_en_q, tag_q, rv_evp_q, rv_evb_q, err_q;
  logic [ADDR_W-1:0] rd_addr_q, addr_o;
  logic              flush, cap, own_evp, own_evb, req_o, req_y, issue, in_rng, at_max, yield;
  assign flush   = bus.instr == I_RST;
  assign cap     = (bus.instr == I_EVP) || (bus.instr == I_EVB);
  assign own_evp = state_q == OWN_EVP;
  assign own_evb = state_q == OWN_EVB;
  assign req_o   = (own_evp & bus.req_evp) | (own_evb & bus.req_evb);
  assign req_y   = (own_evp & bus.req_evb) | (own_evb & bus.req_evp);
  assign addr_o  = own_evp ? bus.addr_evp : bus.addr_evb;
  assign issue   = req_o & ~flush;
  assign in_rng  = int'(addr_o) < S_SIZE;
  assign at_max  = cnt_q >= CNT_W'(MAX_BURST - 1);
  assign yield   = req_y & cap;
  // last_q=1 means EVB owned last, so EVP wins the next tie
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      if (cap && (bus.req_evp || bus.req_evb))
        state_d = (bus.req_evp && (!bus.req_evb || last_q)) ? OWN_EVP : OWN_EVB;
    end else if (!req_o || (at_max && yield)) begin
      state_d = yield ? (own_evp ? OWN_EVB : OWN_EVP) : IDLE;
      last_d  = own_evb;
      cnt_d   = '0;
    end else if (cnt_q != CNT_W'(MAX_BURST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      tag_q     <= 1'b0;
      rv_evp_q  <= 1'b0;
      rv_evb_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      rd_en_q  <= issue & in_rng;
      err_q    <= issue & ~in_rng;
      rv_evp_q <= rd_en_q & ~tag_q & ~flush;
      rv_evb_q <= rd_en_q & tag_q & ~flush;
      if (issue && in_rng) begin
        rd_addr_q <= addr_o;
        tag_q     <= own_evb;
      end
    end
  end
  assign bus.gnt_evp    = own_evp;
  assign bus.gnt_evb    = own_evb;
  assign bus.rd_en_S    = rd_en_q;
  assign bus.rd_addr_S  = rd_addr_q;
  assign bus.rd_data    = DATA_W'(bus.rd_data_S);
  assign bus.rvalid_evp = rv_evp_q;
  assign bus.rvalid_evb = rv_evb_q;
  assign bus.addr_err   = err_q;
`ifdef S_ARB_PERF_EN
  logic [15:0] contend_q;
  logic [7:0]  handover_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      contend_q  <= '0;
      handover_q <= '0;
    end else if (flush) begin
      contend_q  <= '0;
      handover_q <= '0;
    end else begin
      if ((own_evp | own_evb) && bus.req_evp && bus.req_evb && !(&contend_q)) contend_q <= contend_q + 1'b1;
      if (req_o && at_max && yield && !(&handover_q)) handover_q <= handover_q + 1'b1;
    end
  end
  assign bus.contend_cnt  = contend_q;
  assign bus.handover_cnt = handover_q;
`endif
endmodule
